// File: rtl/crc8_frame_ctrl_if.sv
// Byte-source / CRC8-engine signal bundle for the frame sequencer.
// master: byte source plus engine side; slave: the sequencer itself.
interface crc8_frame_ctrl_if #(
  parameter int unsigned CNT_W = 8
) ();
  logic             start;
  logic             abort;
  logic [7:0]       din;
  logic             din_valid;
  logic             din_last;
  logic             din_ready;
  logic             crc_bitval;
  logic             crc_bitstrb;
  logic             crc_enable;
  logic             crc_clear;
  logic [7:0]       crc_in;
  logic [7:0]       crc_out;
  logic             crc_zero;
  logic             done;
  logic             busy;
  logic [CNT_W-1:0] byte_cnt;

  modport master (
    output start, abort, din, din_valid, din_last, crc_in,
    input  din_ready, crc_bitval, crc_bitstrb, crc_enable, crc_clear,
    input  crc_out, crc_zero, done, busy, byte_cnt
  );

  modport slave (
    input  start, abort, din, din_valid, din_last, crc_in,
    output din_ready, crc_bitval, crc_bitstrb, crc_enable, crc_clear,
    output crc_out, crc_zero, done, busy, byte_cnt
  );
endinterface

// File: rtl/crc8_frame_ctrl.sv
// Frame sequencer for a bit-serial CRC8 engine: accepts bytes over valid/ready,
// serialises them MSB first as bitval/bitstrb pairs and reports the final CRC.
module crc8_frame_ctrl #(
  parameter int unsigned CLR_CYCLES = 1,
  parameter int unsigned CNT_W      = 8
) (
  input logic              clk,
  input logic              reset,
  crc8_frame_ctrl_if.slave bus
);

  localparam int unsigned ClrW = 4;

  typedef enum logic [2:0] {StIdle, StClr, StLoad, StSetup, StStrobe, StSettle} state_e;

  state_e           state_q, state_d;
  logic [ClrW-1:0]  clr_cnt_q, clr_cnt_d;
  logic [7:0]       shreg_q, shreg_d;
  logic [2:0]       bit_cnt_q, bit_cnt_d;
  logic             last_q, last_d;
  logic [CNT_W-1:0] byte_cnt_q, byte_cnt_d;

  logic       ready_q, ready_d;
  logic       bitval_q, bitval_d;
  logic       strb_q, strb_d;
  logic       en_q, en_d;
  logic       clear_q, clear_d;
  logic       done_q, done_d;
  logic       busy_q, busy_d;
  logic       zero_q, zero_d;
  logic [7:0] crc_out_q, crc_out_d;

  logic abort_hit;
  logic handshake;

  assign abort_hit = bus.abort && (state_q != StIdle);
  assign handshake = (state_q == StLoad) && bus.din_valid && !bus.abort;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      clr_cnt_q  <= '0;
      shreg_q    <= '0;
      bit_cnt_q  <= '0;
      last_q     <= 1'b0;
      byte_cnt_q <= '0;
      ready_q    <= 1'b0;
      bitval_q   <= 1'b0;
      strb_q     <= 1'b0;
      en_q       <= 1'b0;
      clear_q    <= 1'b1;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
      zero_q     <= 1'b0;
      crc_out_q  <= '0;
    end else begin
      state_q    <= state_d;
      clr_cnt_q  <= clr_cnt_d;
      shreg_q    <= shreg_d;
      bit_cnt_q  <= bit_cnt_d;
      last_q     <= last_d;
      byte_cnt_q <= byte_cnt_d;
      ready_q    <= ready_d;
      bitval_q   <= bitval_d;
      strb_q     <= strb_d;
      en_q       <= en_d;
      clear_q    <= clear_d;
      done_q     <= done_d;
      busy_q     <= busy_d;
      zero_q     <= zero_d;
      crc_out_q  <= crc_out_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    clr_cnt_d  = clr_cnt_q;
    shreg_d    = shreg_q;
    bit_cnt_d  = bit_cnt_q;
    last_d     = last_q;
    byte_cnt_d = byte_cnt_q;
    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          state_d    = StClr;
          clr_cnt_d  = '0;
          byte_cnt_d = '0;
        end
      end
      StClr: begin
        if (clr_cnt_q == ClrW'(CLR_CYCLES - 1)) state_d = StLoad;
        else                                    clr_cnt_d = clr_cnt_q + ClrW'(1);
      end
      StLoad: begin
        if (handshake) begin
          shreg_d   = bus.din;
          last_d    = bus.din_last;
          bit_cnt_d = '0;
          state_d   = StSetup;
          if (byte_cnt_q != '1) byte_cnt_d = byte_cnt_q + CNT_W'(1);
        end
      end
      StSetup: state_d = StStrobe;
      StStrobe: begin
        shreg_d   = {shreg_q[6:0], 1'b0};
        bit_cnt_d = bit_cnt_q + 3'd1;
        if (bit_cnt_q == 3'd7) state_d = last_q ? StSettle : StLoad;
        else                   state_d = StSetup;
      end
      StSettle: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
    if (abort_hit) state_d = StIdle;
  end

  // Outputs are decoded from the next state so every output is a plain register.
  always_comb begin
    ready_d   = (state_d == StLoad);
    strb_d    = (state_d == StStrobe);
    en_d      = (state_d == StSetup) || (state_d == StStrobe);
    clear_d   = (state_d == StClr) || abort_hit;
    done_d    = (state_d == StSettle);
    busy_d    = (state_d != StIdle);
    bitval_d  = 1'b0;
    crc_out_d = crc_out_q;
    zero_d    = zero_q;
    if (state_d == StSetup)       bitval_d = shreg_d[7];
    else if (state_d == StStrobe) bitval_d = bitval_q;
    if (state_d == StSettle) begin
      crc_out_d = bus.crc_in;
      zero_d    = (bus.crc_in == 8'h00);
    end
  end

  assign bus.din_ready   = ready_q;
  assign bus.crc_bitval  = bitval_q;
  assign bus.crc_bitstrb = strb_q;
  assign bus.crc_enable  = en_q;
  assign bus.crc_clear   = clear_q;
  assign bus.crc_out     = crc_out_q;
  assign bus.crc_zero    = zero_q;
  assign bus.done        = done_q;
  assign bus.busy        = busy_q;
  assign bus.byte_cnt    = byte_cnt_q;

endmodule

// File: tb/tb_crc8_frame_ctrl.sv
// Bench for crc8_frame_ctrl: behavioural CRC8 engine, table-driven reference CRC,
// directed frames plus randomized frames with stalls, aborts and resets.
module tb_crc8_frame_ctrl;
  localparam int unsigned ClrCycles = 3;
  localparam int unsigned CntW      = 8;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  int   strb_cnt = 0;
  int   done_cnt = 0;
  int   clr_rise = 0;
  logic bits_q[$];
  logic prev_bitval = 1'b0;
  logic prev_strb   = 1'b0;
  logic prev_clear  = 1'b0;
  logic [7:0] eng = 8'h00;
  logic [7:0] tbl [256];

  crc8_frame_ctrl_if #(.CNT_W(CntW)) bus ();

  crc8_frame_ctrl #(
    .CLR_CYCLES(ClrCycles),
    .CNT_W     (CntW)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // Engine: async clear, shifts one bit on each rising strobe while enabled.
  assign bus.crc_in = eng;
  always @(posedge bus.crc_bitstrb or posedge bus.crc_clear) begin
    if (bus.crc_clear)       eng <= 8'h00;
    else if (bus.crc_enable) eng <= {eng[6:0], 1'b0} ^ ((eng[7] ^ bus.crc_bitval) ? 8'hD5 : 8'h00);
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (bus.crc_bitstrb === 1'b1) begin
      strb_cnt++;
      bits_q.push_back(bus.crc_bitval);
      check_eq("bitval_stable", bus.crc_bitval, prev_bitval);
      check_eq("strobe_width", prev_strb, 1'b0);
      check_eq("enable_at_strobe", bus.crc_enable, 1'b1);
    end
    if (bus.done === 1'b1) done_cnt++;
    if (bus.crc_clear === 1'b1 && !prev_clear) clr_rise++;
    prev_bitval = bus.crc_bitval;
    prev_strb   = (bus.crc_bitstrb === 1'b1);
    prev_clear  = (bus.crc_clear === 1'b1);
  end

  function automatic logic [7:0] ref_crc(input logic [7:0] d[$]);
    logic [7:0] c;
    c = 8'h00;
    foreach (d[i]) c = tbl[c ^ d[i]];
    return c;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic last);
    int   guard;
    logic hs;
    guard = 0;
    bus.din       = b;
    bus.din_last  = last;
    bus.din_valid = 1'b1;
    do begin
      hs = bus.din_ready;
      step();
      guard++;
    end while (!hs && guard < 100);
    check_eq("handshake", hs, 1'b1);
  endtask

  task automatic run_frame(input logic [7:0] data[$], input int stall, input bit poke);
    int         t0, guard, lat, mism, n;
    logic [7:0] exp_crc;
    n       = data.size();
    exp_crc = ref_crc(data);
    strb_cnt = 0;
    done_cnt = 0;
    clr_rise = 0;
    bits_q.delete();
    bus.start = 1'b1;
    t0 = cyc;
    step();
    bus.start = 1'b0;
    for (int i = 0; i < n; i++) begin
      send_byte(data[i], i == n - 1);
      if (poke && i == 0) begin
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
      end
      if (stall > 0 && i != n - 1) begin
        bus.din_valid = 1'b0;
        guard = 0;
        while (!bus.din_ready && guard < 40) begin
          step();
          guard++;
        end
        for (int s = 0; s < stall; s++) begin
          step();
          check_eq("stall_ready", bus.din_ready, 1'b1);
          check_eq("stall_strobe", bus.crc_bitstrb, 1'b0);
        end
      end
    end
    bus.din_valid = 1'b0;
    guard = 0;
    while (!bus.done && guard < 6000) begin
      step();
      guard++;
    end
    lat = cyc - t0;
    check_eq("done", bus.done, 1'b1);
    if (stall == 0) check_eq("latency", lat, 1 + ClrCycles + 17 * n);
    check_eq("crc_out", bus.crc_out, exp_crc);
    check_eq("crc_zero", bus.crc_zero, exp_crc == 8'h00);
    check_eq("byte_cnt", bus.byte_cnt, (n > (1 << CntW) - 1) ? (1 << CntW) - 1 : n);
    check_eq("strobes", strb_cnt, 8 * n);
    mism = 0;
    for (int i = 0; i < n; i++)
      for (int b = 0; b < 8; b++)
        if (8 * i + b >= bits_q.size() || bits_q[8 * i + b] !== data[i][7 - b]) mism++;
    check_eq("bit_seq", mism, 0);
    // A poked START lands in the SETTLE cycle and must be ignored.
    if (poke) bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    check_eq("done_pulse", bus.done, 1'b0);
    check_eq("idle_after", bus.busy, 1'b0);
    check_eq("done_count", done_cnt, 1);
    check_eq("clear_pulses", clr_rise, 1);
  endtask

  task automatic abort_mid(input bit use_reset);
    logic [7:0] prev_out;
    logic [7:0] q[$];
    int         guard;
    prev_out = bus.crc_out;
    done_cnt = 0;
    strb_cnt = 0;
    clr_rise = 0;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    send_byte(8'h01, 1'b0);
    send_byte(8'h00, 1'b1);
    bus.din_valid = 1'b0;
    guard = 0;
    while (strb_cnt < 11 && guard < 100) begin
      step();
      guard++;
    end
    check_eq("abort_reach", strb_cnt, 11);
    if (use_reset) reset = 1'b1;
    else           bus.abort = 1'b1;
    step();
    reset     = 1'b0;
    bus.abort = 1'b0;
    check_eq("ab_clear", bus.crc_clear, 1'b1);
    check_eq("ab_busy", bus.busy, 1'b0);
    check_eq("ab_strobe", bus.crc_bitstrb, 1'b0);
    check_eq("ab_enable", bus.crc_enable, 1'b0);
    check_eq("ab_ready", bus.din_ready, 1'b0);
    if (use_reset) begin
      check_eq("rst_crc_out", bus.crc_out, 8'h00);
      check_eq("rst_zero", bus.crc_zero, 1'b0);
      check_eq("rst_cnt", bus.byte_cnt, 0);
    end else begin
      check_eq("ab_crc_out", bus.crc_out, prev_out);
    end
    step();
    check_eq("ab_clear_drop", bus.crc_clear, 1'b0);
    repeat (30) step();
    check_eq("ab_no_done", done_cnt, 0);
    check_eq("ab_idle", bus.busy, 1'b0);
    check_eq("ab_clear_count", clr_rise, 2);
    q = {8'h80};
    run_frame(q, 0, 1'b0);
    check_eq("ab_new_frame", bus.crc_out, 8'hEF);
  endtask

  initial begin
    logic [7:0] q[$];
    logic [7:0] held;
    int         dc;

    for (int i = 0; i < 256; i++) begin
      logic [7:0] c;
      c = 8'(i);
      for (int b = 0; b < 8; b++) c = c[7] ? ((c << 1) ^ 8'hD5) : (c << 1);
      tbl[i] = c;
    end

    bus.start     = 1'b0;
    bus.abort     = 1'b0;
    bus.din       = 8'h00;
    bus.din_valid = 1'b0;
    bus.din_last  = 1'b0;

    repeat (3) step();
    check_eq("rst_clear", bus.crc_clear, 1'b1);
    check_eq("rst_busy", bus.busy, 1'b0);
    check_eq("rst_ready", bus.din_ready, 1'b0);
    check_eq("rst_done", bus.done, 1'b0);
    check_eq("rst_out", bus.crc_out, 8'h00);
    check_eq("rst_zero0", bus.crc_zero, 1'b0);
    check_eq("rst_bytes", bus.byte_cnt, 0);
    check_eq("rst_strobe", bus.crc_bitstrb, 1'b0);
    reset = 1'b0;
    step();
    check_eq("clear_after_rst", bus.crc_clear, 1'b0);

    q = {8'h01};
    run_frame(q, 0, 1'b0);
    check_eq("vec_01", bus.crc_out, 8'hD5);

    q = {8'h80};
    run_frame(q, 0, 1'b0);
    check_eq("vec_80", bus.crc_out, 8'hEF);
    for (int b = 0; b < 8; b++) check_eq("bitval_80", bits_q[b], b == 0);

    q = {8'h01, 8'h00};
    run_frame(q, 0, 1'b0);
    check_eq("vec_0100", bus.crc_out, 8'h0B);

    q = {8'h01, 8'hD5};
    run_frame(q, 0, 1'b0);
    check_eq("rx_vec", bus.crc_out, 8'h00);
    check_eq("rx_vec_zero", bus.crc_zero, 1'b1);

    q = {8'h01, 8'h00};
    run_frame(q, 5, 1'b0);
    check_eq("stall_vec", bus.crc_out, 8'h0B);

    abort_mid(1'b0);
    abort_mid(1'b1);

    q = {8'hA5, 8'h3C};
    run_frame(q, 0, 1'b1);

    // ABORT while idle must leave everything untouched.
    held = bus.crc_out;
    dc = done_cnt;
    clr_rise = 0;
    bus.abort = 1'b1;
    step();
    bus.abort = 1'b0;
    check_eq("idle_abort_clear", bus.crc_clear, 1'b0);
    check_eq("idle_abort_busy", bus.busy, 1'b0);
    repeat (3) step();
    check_eq("idle_abort_out", bus.crc_out, held);
    check_eq("idle_abort_done", done_cnt, dc);
    check_eq("idle_abort_clr", clr_rise, 0);

    for (int r = 0; r < 16; r++) begin
      int n;
      n = $urandom_range(1, 5);
      q.delete();
      for (int i = 0; i < n; i++) q.push_back(8'($urandom));
      if (r % 4 == 3) q.push_back(ref_crc(q));
      run_frame(q, $urandom_range(0, 2), 1'($urandom_range(0, 1)));
      if (r % 4 == 3) check_eq("rx_rand_zero", bus.crc_zero, 1'b1);
    end

    q.delete();
    for (int i = 0; i < 260; i++) q.push_back(8'($urandom));
    run_frame(q, 0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
